// File: rtl/tri_fb_pkg.sv
// Shared types and default sizing for the triangle framebuffer capture stage.
package tri_fb_pkg;
  localparam int DEF_CW   = 3;
  localparam int DEF_CNTW = 7;
  localparam int GRID_DIM = 2 ** DEF_CW;

  typedef enum logic [1:0] {IDLE, CAPTURE, DRAIN, DONE} fb_state_t;
endpackage

// File: rtl/tri_fb_bitmap.sv
// Occupancy bitmap: one bit per grid pixel, bulk clear, single-pixel set,
// lookup of the addressed pixel and a whole-row read port.
module tri_fb_bitmap
  import tri_fb_pkg::*;
#(
  parameter int CW = DEF_CW
) (
  input  logic              clk,
  input  logic              clear,
  input  logic              set_en,
  input  logic [CW-1:0]     set_x,
  input  logic [CW-1:0]     set_y,
  output logic              was_set,
  input  logic [CW-1:0]     rd_sel,
  output logic [2**CW-1:0]  rd_bits
);
  localparam int GRID = 2 ** CW;

  logic [GRID-1:0] bits_q [GRID];
  logic [GRID-1:0] bits_d [GRID];

  // Clear is applied before the set so a pixel arriving with the clear survives.
  always_comb begin
    for (int r = 0; r < GRID; r++) begin
      bits_d[r] = clear ? '0 : bits_q[r];
      if (set_en && (set_y == CW'(r))) bits_d[r][set_x] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    bits_q <= bits_d;
  end

  assign was_set = bits_q[set_y][set_x];
  assign rd_bits = bits_q[rd_sel];
endmodule

// File: rtl/tri_pixel_fb.sv
// Captures the rasterizer pixel stream into a bitmap, counts distinct pixels,
// then drains rows over valid/ready. Define TRI_FB_DUP_CNT_EN for the dup_cnt output.
module tri_pixel_fb
  import tri_fb_pkg::*;
#(
  parameter int CW   = DEF_CW,
  parameter int CNTW = DEF_CNTW
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              busy_i,
  input  logic              po_i,
  input  logic [CW-1:0]     xo_i,
  input  logic [CW-1:0]     yo_i,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic [CW-1:0]     rd_row,
  output logic [2**CW-1:0]  rd_data,
  output logic [CNTW-1:0]   pix_cnt,
  output logic              ovr,
`ifdef TRI_FB_DUP_CNT_EN
  output logic [CNTW-1:0]   dup_cnt,
`endif
  output logic              frame_done
);
  localparam int                GRID     = 2 ** CW;
  localparam logic [CW-1:0]     LAST_ROW = CW'(GRID - 1);
  localparam logic [CNTW-1:0]   MAX_PIX  = CNTW'(GRID * GRID);

  function automatic logic [CNTW-1:0] sat_inc(input logic [CNTW-1:0] cnt,
                                              input logic [CNTW-1:0] lim);
    return (cnt == lim) ? cnt : cnt + CNTW'(1);
  endfunction

  fb_state_t       state, state_nxt;
  logic [CW-1:0]   row;
  logic [GRID-1:0] row_bits;
  logic            start, cap_wr, was_set, row_acc, new_pix;

  // A capture may start from DONE as well, so a busy rise there is not lost.
  assign start   = busy_i && ((state == IDLE) || (state == DONE));
  assign cap_wr  = po_i && (start || (state == CAPTURE));
  assign row_acc = rd_valid && rd_ready;
  assign new_pix = (state == CAPTURE) && po_i && !was_set;

  tri_fb_bitmap #(.CW(CW)) u_bitmap (
    .clk     (clk),
    .clear   (reset || start),
    .set_en  (cap_wr && !reset),
    .set_x   (xo_i),
    .set_y   (yo_i),
    .was_set (was_set),
    .rd_sel  (row),
    .rd_bits (row_bits)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (busy_i) state_nxt = CAPTURE;
      CAPTURE: if (!busy_i) state_nxt = DRAIN;
      DRAIN:   if (row_acc && (row == LAST_ROW)) state_nxt = DONE;
      DONE:    state_nxt = busy_i ? CAPTURE : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    rd_valid   = 1'b0;
    rd_row     = '0;
    rd_data    = '0;
    frame_done = 1'b0;
    case (state)
      DRAIN: begin
        rd_valid = 1'b1;
        rd_row   = row;
        rd_data  = row_bits;
      end
      DONE:    frame_done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset)                                 row <= '0;
    else if ((state == CAPTURE) && !busy_i)    row <= '0;
    else if (row_acc)                          row <= row + CW'(1);
  end

  always_ff @(posedge clk) begin
    if (reset)        pix_cnt <= '0;
    else if (start)   pix_cnt <= cap_wr ? CNTW'(1) : '0;
    else if (new_pix) pix_cnt <= sat_inc(pix_cnt, MAX_PIX);
  end

  // Any pixel offered while not capturing is dropped and flagged.
  always_ff @(posedge clk) begin
    if (reset || start)                 ovr <= 1'b0;
    else if (po_i && (state != CAPTURE)) ovr <= 1'b1;
  end

`ifdef TRI_FB_DUP_CNT_EN
  always_ff @(posedge clk) begin
    if (reset || start)
      dup_cnt <= '0;
    else if ((state == CAPTURE) && po_i && was_set)
      dup_cnt <= sat_inc(dup_cnt, '1);
  end
`endif

  always_ff @(posedge clk) begin
    if (!reset) assert (pix_cnt <= MAX_PIX);
  end
endmodule

// File: tb/tb_tri_pixel_fb.sv
// Randomized and directed bench for tri_pixel_fb against a plain bitmap model.
module tb_tri_pixel_fb;
  localparam int CW   = 3;
  localparam int CNTW = 7;
  localparam int G    = 8;

  logic            clk = 1'b0;
  logic            reset, busy_i, po_i, rd_ready;
  logic [CW-1:0]   xo_i, yo_i;
  logic            rd_valid, ovr, frame_done;
  logic [CW-1:0]   rd_row;
  logic [G-1:0]    rd_data;
  logic [CNTW-1:0] pix_cnt;
`ifdef TRI_FB_DUP_CNT_EN
  logic [CNTW-1:0] dup_cnt;
`endif

  tri_pixel_fb #(.CW(CW), .CNTW(CNTW)) dut (
    .clk        (clk),
    .reset      (reset),
    .busy_i     (busy_i),
    .po_i       (po_i),
    .xo_i       (xo_i),
    .yo_i       (yo_i),
    .rd_valid   (rd_valid),
    .rd_ready   (rd_ready),
    .rd_row     (rd_row),
    .rd_data    (rd_data),
    .pix_cnt    (pix_cnt),
    .ovr        (ovr),
`ifdef TRI_FB_DUP_CNT_EN
    .dup_cnt    (dup_cnt),
`endif
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic [G-1:0] mbm [G];
  logic [G-1:0] got_rows [G];
  int           mdup;
  bit           movr;
  int           qx[$], qy[$];
  bit           qv[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int model_count();
    int n = 0;
    for (int y = 0; y < G; y++)
      for (int x = 0; x < G; x++)
        if (mbm[y][x]) n++;
    return n;
  endfunction

  task automatic q_clear();
    qx.delete(); qy.delete(); qv.delete();
  endtask

  task automatic q_add(input bit v, input int x, input int y);
    qv.push_back(v); qx.push_back(x); qy.push_back(y);
  endtask

  // Queue entries are capture cycles: all but the last have busy=1, the last has busy=0.
  // stall_mode: 0 always ready, 1 random ready plus stray traffic, 2 five-cycle stall on row 2.
  task automatic run_frame(input int stall_mode, input int abort_row, input bit b2b);
    int  r, tick, stalls;
    bit  rdy, stray;
    for (int i = 0; i < qx.size(); i++) begin
      if (i == 0) begin
        for (int y = 0; y < G; y++) mbm[y] = '0;
        mdup = 0;
        movr = 0;
      end
      if (qv[i]) begin
        if (mbm[qy[i]][qx[i]]) mdup++;
        mbm[qy[i]][qx[i]] = 1'b1;
      end
      busy_i = (i != qx.size() - 1);
      po_i   = qv[i];
      xo_i   = qx[i][CW-1:0];
      yo_i   = qy[i][CW-1:0];
      step();
      if (i == 0) begin
        chk("ovr_clr_at_start", ovr, 0);
        chk("no_done_at_start", frame_done, 0);
      end
    end
    busy_i = 1'b0;
    po_i   = 1'b0;
    chk("pix_cnt", pix_cnt, model_count());
`ifdef TRI_FB_DUP_CNT_EN
    chk("dup_cnt", dup_cnt, mdup);
`endif
    r = 0; tick = 0; stalls = 0;
    while (r < G && tick < 200) begin
      case (stall_mode)
        1:       rdy = ($urandom_range(0, 2) != 0);
        2:       rdy = !(r == 2 && stalls < 5);
        default: rdy = 1'b1;
      endcase
      if (stall_mode == 2 && !rdy) stalls++;
      stray    = (stall_mode == 1) && ($urandom_range(0, 7) == 0);
      rd_ready = rdy;
      po_i     = stray;
      busy_i   = (stall_mode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
      xo_i     = CW'($urandom_range(0, G - 1));
      yo_i     = CW'($urandom_range(0, G - 1));
      chk("rd_valid", rd_valid, 1);
      chk("rd_row", rd_row, r);
      chk("rd_data", rd_data, mbm[r]);
      chk("no_early_done", frame_done, 0);
      got_rows[r] = rd_data;
      if (r == abort_row) begin
        reset = 1'b1;
        step();
        reset = 1'b0; po_i = 1'b0; busy_i = 1'b0;
        chk("rst_rd_valid", rd_valid, 0);
        chk("rst_pix_cnt", pix_cnt, 0);
        chk("rst_ovr", ovr, 0);
        chk("rst_rd_data", rd_data, 0);
        chk("rst_rd_row", rd_row, 0);
        movr = 0;
        for (int y = 0; y < G; y++) mbm[y] = '0;
        return;
      end
      step();
      if (stray) movr = 1;
      if (rdy) r++;
      tick++;
    end
    chk("drain_rows_accepted", r, G);
    if (stall_mode == 2) chk("stall_cycles", stalls, 5);
    busy_i = 1'b0; po_i = 1'b0; rd_ready = 1'b0;
    chk("frame_done", frame_done, 1);
    chk("done_rd_valid", rd_valid, 0);
    chk("done_ovr", ovr, movr);
    chk("done_pix_cnt", pix_cnt, model_count());
    if (!b2b) begin
      step();
      chk("done_one_cycle", frame_done, 0);
      chk("idle_rd_valid", rd_valid, 0);
    end
  endtask

  task automatic random_queue(input int n);
    q_clear();
    for (int i = 0; i < n; i++)
      q_add($urandom_range(0, 3) != 0, $urandom_range(0, G - 1), $urandom_range(0, G - 1));
  endtask

  initial begin
    reset = 1'b1; busy_i = 1'b0; po_i = 1'b0; xo_i = '0; yo_i = '0; rd_ready = 1'b0;
    step();
    step();
    chk("reset_rd_valid", rd_valid, 0);
    chk("reset_rd_row", rd_row, 0);
    chk("reset_rd_data", rd_data, 0);
    chk("reset_pix_cnt", pix_cnt, 0);
    chk("reset_ovr", ovr, 0);
    chk("reset_frame_done", frame_done, 0);
    reset = 1'b0;
    step();

    // Right triangle x,y>=1, x+y<=6.
    q_clear();
    for (int y = 1; y <= 5; y++)
      for (int x = 1; x + y <= 6; x++)
        q_add(1'b1, x, y);
    q_add(1'b0, 0, 0);
    run_frame(0, -1, 1'b0);
    begin
      logic [G-1:0] tri_rows [G];
      tri_rows = '{8'h00, 8'h3E, 8'h1E, 8'h0E, 8'h06, 8'h02, 8'h00, 8'h00};
      for (int y = 0; y < G; y++) chk($sformatf("tri_row%0d", y), got_rows[y], tri_rows[y]);
    end
    chk("tri_pix_cnt", pix_cnt, 15);

    // Duplicate writes to (3,4).
    q_clear();
    q_add(1'b1, 3, 4); q_add(1'b1, 3, 4); q_add(1'b1, 3, 4); q_add(1'b0, 0, 0);
    run_frame(0, -1, 1'b0);
    chk("dup_pix_cnt", pix_cnt, 1);
    chk("dup_row4", got_rows[4], 8'h08);
`ifdef TRI_FB_DUP_CNT_EN
    chk("dup_cnt_value", dup_cnt, 2);
`endif

    // Backpressure on row 2.
    random_queue(20);
    run_frame(2, -1, 1'b0);

    // Stray pixel in IDLE.
    busy_i = 1'b0; po_i = 1'b1; xo_i = 3'd7; yo_i = 3'd7;
    step();
    po_i = 1'b0;
    chk("stray_ovr_set", ovr, 1);
    q_clear();
    q_add(1'b1, 1, 1); q_add(1'b1, 2, 6); q_add(1'b0, 0, 0);
    run_frame(0, -1, 1'b0);
    chk("stray_row7_absent", got_rows[7], 8'h00);

    // Reset mid-drain at row 3, then a clean frame.
    random_queue(25);
    run_frame(0, 3, 1'b0);
    random_queue(10);
    run_frame(0, -1, 1'b0);

    // Back-to-back: second frame starts in the DONE cycle.
    random_queue(30);
    run_frame(0, -1, 1'b1);
    q_clear();
    q_add(1'b1, 0, 0); q_add(1'b1, 7, 3); q_add(1'b0, 0, 0);
    run_frame(0, -1, 1'b0);
    chk("b2b_pix_cnt", pix_cnt, 2);

    // Random frames with random backpressure, stray traffic and chaining.
    for (int f = 0; f < 25; f++) begin
      random_queue($urandom_range(2, 40));
      run_frame($urandom_range(0, 1), -1, (f != 24) && ($urandom_range(0, 1) != 0));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
endmodule
